// File: rtl/z80_intr_ctrl_pkg.sv
// ============================================================================
// Module : z80_intr_ctrl_pkg
// Brief  : Shared encodings for the Z80 interrupt controller: FSM states,
//          interrupt-mode codes, fixed service addresses, IM2 pointer helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package z80_intr_ctrl_pkg;

  // Controller FSM encoding
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    INT_REQ = 2'b01,
    NMI_REQ = 2'b10
  } state_t;

  // Interrupt mode codes as written by IM n
  localparam logic [1:0] IM_MODE0 = 2'd0;
  localparam logic [1:0] IM_MODE1 = 2'd1;
  localparam logic [1:0] IM_MODE2 = 2'd2;
  localparam logic [1:0] IM_BAD   = 2'd3;

  // Fixed service addresses
  localparam logic [15:0] ADDR_NMI = 16'h0066;
  localparam logic [15:0] ADDR_IM1 = 16'h0038;

  // IM2 table pointer: I register in the high byte, per-source slot in the low byte
  function automatic logic [15:0] im2_ptr(input logic [7:0] ireg,
                                          input logic [7:0] base,
                                          input logic [2:0] src);
    logic [7:0] lo;
    lo = base + {4'b0000, src, 1'b0};
    return {ireg, lo};
  endfunction

endpackage

`default_nettype wire

// File: rtl/intr_prio_enc.sv
// ============================================================================
// Module : intr_prio_enc
// Brief  : Fixed-priority encoder; reports the lowest set request index and
//          whether any request is set. Index 0 wins.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module intr_prio_enc #(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic [2:0]         idx,
  output logic               valid
);

  // Scan from the top down so the lowest set index is the last one written
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = 3'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/z80_intr_ctrl.sv
// ============================================================================
// Module : z80_intr_ctrl
// Brief  : Multi-source interrupt controller for the Z80-compatible core.
//          NUM_IRQ prioritised maskable sources plus edge-detected NMI,
//          IFF1/IFF2 with one-instruction EI delay, IM0/IM1/IM2 targets.
// Config : Z80_INTR_IRQ_LATCH_EN - when defined, irq_in bits are rising-edge
//          captured into sticky pending bits; otherwise sources are levels.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module z80_intr_ctrl
  import z80_intr_ctrl_pkg::*;
#(
  parameter int          NUM_IRQ      = 4,
  parameter logic [7:0]  VEC_BASE     = 8'hE0,
  parameter logic [15:0] IM0_RST_ADDR = 16'h0038
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               nmi_in,
  input  logic               ei_dec,
  input  logic               di_dec,
  input  logic               retn_dec,
  input  logic               im_wr,
  input  logic [1:0]         im_val,
  input  logic [7:0]         i_reg,
  input  logic               instr_retire,
  input  logic               mem_pipe_stall,
  input  logic               flush0,
  output logic               interrupt_RQ,
  output logic               intern_INT,
  output logic               intern_NMI,
  output logic [15:0]        int_addr,
  output logic               int_is_vec,
  output logic [2:0]         int_src,
  output logic               IFF1,
  output logic               IFF2,
  output logic [1:0]         im_mode
);

  state_t             state;
  state_t             next_state;
  logic               ei_pend;
  logic               nmi_prev;
  logic               nmi_pend;
  logic               nmi_edge;
  logic [NUM_IRQ-1:0] req_vec;
  logic [2:0]         prio_idx;
  logic               prio_valid;
  logic               eligible;
  logic               any_flag_dec;
  logic               enter_int;
  logic               enter_nmi;
  logic               iff1_d;
  logic               iff2_d;
  logic               ei_pend_d;

`ifdef Z80_INTR_IRQ_LATCH_EN
  logic [NUM_IRQ-1:0] irq_prev;
  logic [NUM_IRQ-1:0] pend_q;
  logic [NUM_IRQ-1:0] svc_clr;

  // One-hot clear of the source being serviced in the intern_INT cycle
  always_comb begin
    svc_clr = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      svc_clr[i] = intern_INT && (int_src == 3'(i));
    end
  end

  // Sticky pending bits; edges are captured regardless of the mask, and a
  // new edge in the clear cycle wins so it is not dropped
  always_ff @(posedge CLK) begin
    if (RST) begin
      irq_prev <= '0;
      pend_q   <= '0;
    end else if (!mem_pipe_stall) begin
      irq_prev <= irq_in;
      pend_q   <= (pend_q & ~svc_clr) | (irq_in & ~irq_prev);
    end
  end

  assign req_vec = pend_q & irq_mask;
`else
  assign req_vec = irq_in & irq_mask;
`endif

  intr_prio_enc #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio (
    .req   (req_vec),
    .idx   (prio_idx),
    .valid (prio_valid)
  );

  assign nmi_edge     = nmi_in && !nmi_prev;
  assign eligible     = prio_valid && IFF1 && !ei_pend;
  assign any_flag_dec = di_dec || retn_dec || ei_dec;
  assign enter_int    = (state == IDLE) && (next_state == INT_REQ);
  assign enter_nmi    = (state == IDLE) && (next_state == NMI_REQ);

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // FSM next state; a stall freezes the machine where it is
  always_comb begin
    next_state = state;
    if (!mem_pipe_stall) begin
      case (state)
        IDLE: begin
          if (nmi_pend)                         next_state = NMI_REQ;
          else if (eligible && !any_flag_dec)   next_state = INT_REQ;
        end
        INT_REQ, NMI_REQ: begin
          if (flush0) next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // FSM outputs; service pulses fire in the flush0 cycle, never under stall or reset
  always_comb begin
    interrupt_RQ = (state != IDLE);
    intern_INT   = !RST && !mem_pipe_stall && (state == INT_REQ) && flush0;
    intern_NMI   = !RST && !mem_pipe_stall && (state == NMI_REQ) && flush0;
  end

  // NMI edge detector keeps sampling through stalls so no edge is lost
  always_ff @(posedge CLK) begin
    if (RST) begin
      nmi_prev <= 1'b0;
      nmi_pend <= 1'b0;
    end else begin
      nmi_prev <= nmi_in;
      nmi_pend <= (nmi_pend && !enter_nmi) || nmi_edge;
    end
  end

  // Interrupt flip-flop update: decoded instructions first, FSM entry overrides
  always_comb begin
    iff1_d    = IFF1;
    iff2_d    = IFF2;
    ei_pend_d = ei_pend;
    if (retn_dec) iff1_d = IFF2;
    if (di_dec) begin
      ei_pend_d = 1'b0;
      iff1_d    = 1'b0;
      iff2_d    = 1'b0;
    end else if (ei_dec) begin
      ei_pend_d = 1'b1;
    end else if (ei_pend && instr_retire) begin
      ei_pend_d = 1'b0;
      iff1_d    = 1'b1;
      iff2_d    = 1'b1;
    end
    if (enter_int) begin
      iff1_d = 1'b0;
      iff2_d = 1'b0;
    end
    if (enter_nmi) iff1_d = 1'b0;
  end

  // Flag and mode registers, frozen while the memory pipe stalls
  always_ff @(posedge CLK) begin
    if (RST) begin
      IFF1    <= 1'b0;
      IFF2    <= 1'b0;
      ei_pend <= 1'b0;
      im_mode <= IM_MODE0;
    end else if (!mem_pipe_stall) begin
      IFF1    <= iff1_d;
      IFF2    <= iff2_d;
      ei_pend <= ei_pend_d;
      if (im_wr && (im_val != IM_BAD)) im_mode <= im_val;
    end
  end

  // Service target latched on FSM entry and held until the next entry
  always_ff @(posedge CLK) begin
    if (RST) begin
      int_addr   <= '0;
      int_is_vec <= 1'b0;
      int_src    <= '0;
    end else if (enter_nmi) begin
      int_addr   <= ADDR_NMI;
      int_is_vec <= 1'b0;
    end else if (enter_int) begin
      int_src <= prio_idx;
      case (im_mode)
        IM_MODE1: begin
          int_addr   <= ADDR_IM1;
          int_is_vec <= 1'b0;
        end
        IM_MODE2: begin
          int_addr   <= im2_ptr(i_reg, VEC_BASE, prio_idx);
          int_is_vec <= 1'b1;
        end
        default: begin
          int_addr   <= IM0_RST_ADDR;
          int_is_vec <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_z80_intr_ctrl.sv
// ============================================================================
// Module : tb_z80_intr_ctrl
// Brief  : Directed self-checking bench for z80_intr_ctrl (NUM_IRQ=4,
//          VEC_BASE=E0, IM0_RST_ADDR=0038).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_z80_intr_ctrl;

  logic        CLK;
  logic        RST;
  logic [3:0]  irq_in;
  logic [3:0]  irq_mask;
  logic        nmi_in;
  logic        ei_dec;
  logic        di_dec;
  logic        retn_dec;
  logic        im_wr;
  logic [1:0]  im_val;
  logic [7:0]  i_reg;
  logic        instr_retire;
  logic        mem_pipe_stall;
  logic        flush0;
  logic        interrupt_RQ;
  logic        intern_INT;
  logic        intern_NMI;
  logic [15:0] int_addr;
  logic        int_is_vec;
  logic [2:0]  int_src;
  logic        IFF1;
  logic        IFF2;
  logic [1:0]  im_mode;

  int checks = 0;
  int errors = 0;

  z80_intr_ctrl #(
    .NUM_IRQ      (4),
    .VEC_BASE     (8'hE0),
    .IM0_RST_ADDR (16'h0038)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .irq_in         (irq_in),
    .irq_mask       (irq_mask),
    .nmi_in         (nmi_in),
    .ei_dec         (ei_dec),
    .di_dec         (di_dec),
    .retn_dec       (retn_dec),
    .im_wr          (im_wr),
    .im_val         (im_val),
    .i_reg          (i_reg),
    .instr_retire   (instr_retire),
    .mem_pipe_stall (mem_pipe_stall),
    .flush0         (flush0),
    .interrupt_RQ   (interrupt_RQ),
    .intern_INT     (intern_INT),
    .intern_NMI     (intern_NMI),
    .int_addr       (int_addr),
    .int_is_vec     (int_is_vec),
    .int_src        (int_src),
    .IFF1           (IFF1),
    .IFF2           (IFF2),
    .im_mode        (im_mode)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Count one comparison and report it if the observed value is wrong
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  // EI retires, then one more instruction retires, then one quiet cycle
  task automatic enable_ints();
    ei_dec = 1'b1; instr_retire = 1'b1;
    tick();
    ei_dec = 1'b0;
    tick();
    instr_retire = 1'b0;
    tick();
  endtask

  initial begin
    RST = 1'b1; irq_in = '0; irq_mask = '0; nmi_in = 1'b0; ei_dec = 1'b0;
    di_dec = 1'b0; retn_dec = 1'b0; im_wr = 1'b0; im_val = 2'd0; i_reg = 8'h00;
    instr_retire = 1'b0; mem_pipe_stall = 1'b0; flush0 = 1'b0;
    do_reset();

    // ---- reset state ----
    check_eq("rst_flags", {26'd0, interrupt_RQ, intern_INT, intern_NMI, int_is_vec, IFF1, IFF2}, 32'd0);
    check_eq("rst_addr", {16'd0, int_addr}, 32'h0);
    check_eq("rst_mode_src", {27'd0, im_mode, int_src}, 32'd0);

    // ---- IM1, EI delay, level irq[2] ----
    im_wr = 1'b1; im_val = 2'd1;
    tick();
    im_wr = 1'b0;
    check_eq("im1_mode", {30'd0, im_mode}, 32'd1);
    irq_mask = 4'hF; irq_in = 4'b0100;
    ei_dec = 1'b1; instr_retire = 1'b1;
    tick();
    ei_dec = 1'b0; instr_retire = 1'b0;
    check_eq("ei_iff1_after_ei", {31'd0, IFF1}, 32'd0);
    tick();
    check_eq("ei_iff1_gap", {31'd0, IFF1}, 32'd0);
    check_eq("ei_rq_gap", {31'd0, interrupt_RQ}, 32'd0);
    instr_retire = 1'b1;
    tick();
    instr_retire = 1'b0;
    check_eq("ei_iff_set", {30'd0, IFF1, IFF2}, 32'h3);
    check_eq("ei_rq_not_yet", {31'd0, interrupt_RQ}, 32'd0);
    tick();
    check_eq("im1_rq", {31'd0, interrupt_RQ}, 32'd1);
    check_eq("im1_addr", {16'd0, int_addr}, 32'h0038);
    check_eq("im1_src", {29'd0, int_src}, 32'd2);
    check_eq("im1_iff_clr", {30'd0, IFF1, IFF2}, 32'd0);
    irq_in = 4'b0000;
    tick();
    check_eq("im1_rq_latched", {31'd0, interrupt_RQ}, 32'd1);
    flush0 = 1'b1;
    #1;
    check_eq("im1_pulse", {30'd0, intern_INT, intern_NMI}, 32'h2);
    tick();
    flush0 = 1'b0;
    check_eq("im1_done", {30'd0, interrupt_RQ, intern_INT}, 32'd0);
    check_eq("im1_addr_held", {16'd0, int_addr}, 32'h0038);

    // ---- IM2 vector, irq 1010 ----
    im_wr = 1'b1; im_val = 2'd2; i_reg = 8'h40;
    tick();
    im_wr = 1'b0;
    irq_in = 4'b1010;
    enable_ints();
    check_eq("im2_rq", {31'd0, interrupt_RQ}, 32'd1);
    check_eq("im2_src", {29'd0, int_src}, 32'd1);
    check_eq("im2_addr", {16'd0, int_addr}, 32'h40E2);
    check_eq("im2_vec", {31'd0, int_is_vec}, 32'd1);

    // ---- NMI edge during INT_REQ ----
    nmi_in = 1'b1;
    tick();
    nmi_in = 1'b0; flush0 = 1'b1;
    #1;
    check_eq("nmi_int_first", {30'd0, intern_INT, intern_NMI}, 32'h2);
    tick();
    flush0 = 1'b0;
    check_eq("nmi_idle_gap", {31'd0, interrupt_RQ}, 32'd0);
    tick();
    check_eq("nmi_rq", {31'd0, interrupt_RQ}, 32'd1);
    check_eq("nmi_addr", {16'd0, int_addr}, 32'h0066);
    check_eq("nmi_vec", {31'd0, int_is_vec}, 32'd0);
    check_eq("nmi_iff", {30'd0, IFF1, IFF2}, 32'd0);
    flush0 = 1'b1;
    #1;
    check_eq("nmi_pulse", {30'd0, intern_INT, intern_NMI}, 32'h1);
    tick();
    flush0 = 1'b0; retn_dec = 1'b1;
    tick();
    retn_dec = 1'b0;
    check_eq("retn_iff1", {31'd0, IFF1}, 32'd0);
    check_eq("retn_rq", {31'd0, interrupt_RQ}, 32'd0);
    im_wr = 1'b1; im_val = 2'd3;
    tick();
    im_wr = 1'b0;
    check_eq("im3_ignored", {30'd0, im_mode}, 32'd2);

    // ---- EI+DI together, then DI while EI pending ----
    irq_in = 4'b0000;
    enable_ints();
    check_eq("eidi_pre_iff1", {31'd0, IFF1}, 32'd1);
    ei_dec = 1'b1; di_dec = 1'b1; instr_retire = 1'b1; irq_in = 4'b0001;
    tick();
    ei_dec = 1'b0; di_dec = 1'b0;
    tick();
    instr_retire = 1'b0;
    tick();
    tick();
    check_eq("eidi_iff", {30'd0, IFF1, IFF2}, 32'd0);
    check_eq("eidi_rq", {31'd0, interrupt_RQ}, 32'd0);
    ei_dec = 1'b1; instr_retire = 1'b1;
    tick();
    ei_dec = 1'b0; instr_retire = 1'b0; di_dec = 1'b1;
    tick();
    di_dec = 1'b0; instr_retire = 1'b1;
    tick();
    instr_retire = 1'b0;
    tick();
    tick();
    check_eq("dipend_iff", {30'd0, IFF1, IFF2}, 32'd0);
    check_eq("dipend_rq", {31'd0, interrupt_RQ}, 32'd0);

    // ---- stall in INT_REQ with flush0 held ----
    irq_in = 4'b0000;
    do_reset();
    irq_mask = 4'hF; irq_in = 4'b1000;
    enable_ints();
    check_eq("stall_rq", {31'd0, interrupt_RQ}, 32'd1);
    check_eq("stall_src", {29'd0, int_src}, 32'd3);
    check_eq("im0_addr", {16'd0, int_addr}, 32'h0038);
    mem_pipe_stall = 1'b1; flush0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("stall_no_pulse", {31'd0, intern_INT}, 32'd0);
      tick();
      check_eq("stall_held", {31'd0, interrupt_RQ}, 32'd1);
    end
    mem_pipe_stall = 1'b0;
    #1;
    check_eq("stall_release_pulse", {31'd0, intern_INT}, 32'd1);
    tick();
    flush0 = 1'b0;
    check_eq("stall_done", {31'd0, interrupt_RQ}, 32'd0);

    // ---- reset mid-request ----
    enable_ints();
    check_eq("rstmid_rq", {31'd0, interrupt_RQ}, 32'd1);
    RST = 1'b1; flush0 = 1'b1;
    #1;
    check_eq("rstmid_no_pulse", {31'd0, intern_INT}, 32'd0);
    tick();
    RST = 1'b0; flush0 = 1'b0;
    check_eq("rstmid_idle", {29'd0, interrupt_RQ, IFF1, IFF2}, 32'd0);
    check_eq("rstmid_addr", {16'd0, int_addr}, 32'h0);

    // ---- one-cycle irq[0] pulse while interrupts are disabled ----
    irq_in = 4'b0000;
    do_reset();
    irq_mask = 4'hF; irq_in = 4'b0001;
    tick();
    irq_in = 4'b0000;
    tick();
    enable_ints();
`ifdef Z80_INTR_IRQ_LATCH_EN
    check_eq("latch_rq", {31'd0, interrupt_RQ}, 32'd1);
    check_eq("latch_src", {29'd0, int_src}, 32'd0);
    flush0 = 1'b1;
    #1;
    check_eq("latch_pulse", {31'd0, intern_INT}, 32'd1);
    tick();
    flush0 = 1'b0;
    enable_ints();
    check_eq("latch_cleared", {31'd0, interrupt_RQ}, 32'd0);
`else
    check_eq("level_pulse_lost", {31'd0, interrupt_RQ}, 32'd0);
    check_eq("level_iff1_on", {31'd0, IFF1}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/z80_intr_ctrl.md
Name: z80_intr_ctrl

Overview:
- Multi-source interrupt controller for the Z80-compatible RISC core; next generation of the core's single-INT/NMI handler.
- Arbitrates NUM_IRQ maskable sources plus an edge-detected NMI.
- Tracks IFF1/IFF2 with the one-instruction EI delay and supports interrupt modes IM0/IM1/IM2.
- Raises an interrupt request to the pipeline flush units and supplies the service target address once flush0 completes.

Parameters:
- NUM_IRQ, 4, number of maskable sources (1..8); index 0 is highest priority.
- VEC_BASE, 8'hE0, low byte of IM2 vector for source 0; source k uses VEC_BASE + 2*k.
- IM0_RST_ADDR, 16'h0038, service address used in IM0 (treated as RST 38h).

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- irq_in  in  NUM_IRQ  maskable interrupt sources
- irq_mask  in  NUM_IRQ  1 = source enabled
- nmi_in  in  1  non-maskable request, rising-edge sensitive
- ei_dec  in  1  EI decoded in current instruction
- di_dec  in  1  DI decoded
- retn_dec  in  1  RETN decoded (IFF1 <= IFF2)
- im_wr  in  1  IM n decoded
- im_val  in  2  new mode: 0, 1, 2 (3 ignored)
- i_reg  in  8  Z80 I register
- instr_retire  in  1  one instruction retires this cycle
- mem_pipe_stall  in  1  freeze all state
- flush0  in  1  pipeline flush complete
- interrupt_RQ  out  1  request pending to flush units
- intern_INT  out  1  one-cycle pulse: maskable service begins
- intern_NMI  out  1  one-cycle pulse: NMI service begins
- int_addr  out  16  service target: jump address, or IM2 table pointer
- int_is_vec  out  1  int_addr is an IM2 table pointer (core reads the word there)
- int_src  out  3  index of the serviced source
- IFF1, IFF2  out  1  interrupt flip-flops
- im_mode  out  2  current interrupt mode

Behaviour:
- Reset: state=IDLE; IFF1=IFF2=0; im_mode=0; ei_pend=0; nmi_prev=0; nmi_pend=0. All outputs 0.
- mem_pipe_stall=1: every register holds. Pulses are suppressed. Edge detection on nmi_in still samples, so no NMI edge is lost.
- nmi_pend is set on a rising edge of nmi_in. It is cleared when the FSM enters NMI_REQ.
- EI: sets ei_pend. IFF1 and IFF2 become 1 on the first instr_retire strictly after the EI-retire cycle; ei_pend then clears.
  - DI while ei_pend: clears ei_pend and IFF1/IFF2 immediately.
  - DI otherwise: clears IFF1/IFF2. DI has priority over EI in the same cycle.
- RETN: IFF1 <= IFF2.
- IM n: im_mode <= im_val when im_wr is asserted and im_val != 3.
- Eligible maskable request: |(irq_in & irq_mask) && IFF1 && !ei_pend.
- FSM:
  - IDLE -> NMI_REQ if nmi_pend (NMI has highest priority).
  - Otherwise IDLE -> INT_REQ if an eligible request exists and none of di_dec, retn_dec, ei_dec is active this cycle.
  - On entry to INT_REQ: latch int_src = lowest set index of (irq_in & irq_mask); IFF1, IFF2 <= 0.
  - On entry to NMI_REQ: IFF2 unchanged; IFF1 <= 0.
  - INT_REQ / NMI_REQ -> IDLE when flush0=1. intern_INT or intern_NMI pulses in that same cycle.
  - interrupt_RQ = state != IDLE (registered state, no combinational path).
- int_addr is latched on FSM entry:
  - NMI: 16'h0066.
  - IM0: IM0_RST_ADDR.
  - IM1: 16'h0038.
  - IM2: {i_reg, VEC_BASE + 2*int_src}, with int_is_vec=1.
  - int_addr and int_is_vec are held until the next entry.
- NMI edge arriving while in INT_REQ: sets nmi_pend. It is serviced after return to IDLE (minimum one IDLE cycle).
- A maskable source deasserting while in INT_REQ does not cancel the request (latched).
- Reset mid-request: returns to IDLE; no pulse is emitted.

Optional Feature:
- Macro: Z80_INTR_IRQ_LATCH_EN.
- Defined:
  - Each irq_in bit is rising-edge detected into a sticky pending bit (pend_q).
  - Arbitration uses pend_q & irq_mask.
  - The serviced bit clears in the intern_INT cycle.
  - Masked edges are still captured.
- Undefined: sources are level-sensitive; no pending storage.

Decomposition:
- Shared package/include z80_intr.def.v holds:
  - state encodings IDLE=2'b00, INT_REQ=2'b01, NMI_REQ=2'b10;
  - IM mode codes;
  - fixed addresses 16'h0066 and 16'h0038.
- One sub-module, intr_prio_enc (parametrised NUM_IRQ), returns the lowest set index plus a valid bit.

Test Plan:
- Reset, then EI retires, then one more instruction retires with irq_in[2]=1, mask=all, IM1:
  - IFF1 rises only on the second retire;
  - interrupt_RQ next cycle;
  - flush0 -> intern_INT pulse, int_addr=16'h0038, int_src=2, IFF1=IFF2=0.
- IM2, i_reg=8'h40, irq_in=4'b1010, IFF1=1 -> int_src=1, int_addr=16'h40E2, int_is_vec=1.
- NMI edge during INT_REQ with IFF1=1 before entry:
  - INT completes first;
  - then NMI_REQ, int_addr=16'h0066, IFF2 stays 0 (it was cleared by INT);
  - RETN then leaves IFF1=0.
- EI and DI decoded together, or DI with ei_pend set -> IFF1=IFF2=0; no request for asserted irq_in.
- mem_pipe_stall held 5 cycles in INT_REQ with flush0=1 -> no pulse, state held; pulse on the first unstalled cycle.
- With Z80_INTR_IRQ_LATCH_EN: a 1-cycle irq_in[0] pulse while IFF1=0, then EI -> serviced after the EI delay, pend_q[0] cleared. Without the macro: the pulse is lost.
